// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and transfer helpers for the SRAM subordinate.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_mask = 4'b0001 << addr;
            HSIZE_HALF: byte_mask = 4'b0011 << {addr[1], 1'b0};
            default:    byte_mask = 4'b1111;
        endcase
    endfunction

    // Oversized or misaligned transfers are answered with ERROR.
    function automatic logic xfer_bad(input logic [2:0] size, input logic [1:0] addr);
        xfer_bad = (size > HSIZE_WORD) ||
                   ((size == HSIZE_HALF) && addr[0]) ||
                   ((size == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ahbl_sram_ctrl_if.sv
// AHB-Lite bus signals seen by the SRAM subordinate.
interface ahbl_sram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted-write buffer: holds a write displaced by a read and
// merges its bytes into read data until it is drained to the SRAM.
module ahbl_sram_wbuf #(
    parameter int unsigned AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rd_req_i,
    input  logic          wr_dp_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [3:0]    wr_mask_i,
    input  logic [31:0]   wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [31:0]   sram_do_i,
    output logic          drain_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    mask_o,
    output logic [31:0]   data_o,
    output logic [31:0]   fwd_data_o
);
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   data_q, data_d;
    logic          load;
    logic          hit;

    assign drain_o = valid_q & ~rd_req_i;
    assign load    = wr_dp_i & (rd_req_i | valid_q);

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = wr_addr_i;
            mask_d  = wr_mask_i;
            data_d  = wr_data_i;
        end else if (drain_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    // The register value is used even in the drain cycle, while the SRAM is still stale.
    assign hit = valid_q & (addr_q == rd_addr_i);

    always_comb begin
        fwd_data_o = sram_do_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (hit && mask_q[i]) fwd_data_o[8*i +: 8] = data_q[8*i +: 8];
        end
    end

    assign addr_o = addr_q;
    assign mask_o = mask_q;
    assign data_o = data_q;

    a_no_load_when_valid: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(load && valid_q)
    );

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite subordinate for a single-port synchronous SRAM macro with
// zero-wait reads/writes and a two-cycle ERROR response for bad transfers.
module ahbl_sram_ctrl
    import ahbl_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahbl_sram_ctrl_if.slave ahb,
    output logic            SRAM_EN,
    output logic [3:0]      SRAM_WE,
    output logic [AW-1:0]   SRAM_A,
    output logic [31:0]     SRAM_DI,
    input  logic [31:0]     SRAM_DO
);
    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} rsp_state_e;

    rsp_state_e    state_q, state_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]    dp_mask_q, dp_mask_d;

    logic          acc, bad, rd_req, wr_dp;
    logic          buf_drain;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_mask;
    logic [31:0]   buf_data, fwd_data;
    logic          unused_bits;

    assign unused_bits = &{1'b0, ahb.HADDR[31:AW+2], ahb.HTRANS[0]};

    assign acc    = HRESETn & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign bad    = xfer_bad(ahb.HSIZE, ahb.HADDR[1:0]);
    assign rd_req = acc & ~bad & ~ahb.HWRITE;
    assign wr_dp  = dp_valid_q & dp_write_q;

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_mask_d  = dp_mask_q;
        if (ahb.HREADY) begin
            dp_valid_d = acc & ~bad;
            dp_write_d = ahb.HWRITE;
            dp_addr_d  = ahb.HADDR[AW+1:2];
            dp_mask_d  = byte_mask(ahb.HSIZE, ahb.HADDR[1:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OKAY: if (acc && bad) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = (acc && bad) ? ST_ERR1 : ST_OKAY;
            default: state_d = ST_OKAY;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_OKAY;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= '0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_mask_q  <= dp_mask_d;
        end
    end

    // Fixed priority: read address phase, buffer drain, direct write.
    always_comb begin
        SRAM_EN = 1'b0;
        SRAM_WE = '0;
        SRAM_A  = '0;
        SRAM_DI = '0;
        if (rd_req) begin
            SRAM_EN = 1'b1;
            SRAM_A  = ahb.HADDR[AW+1:2];
        end else if (buf_drain) begin
            SRAM_EN = 1'b1;
            SRAM_WE = buf_mask;
            SRAM_A  = buf_addr;
            SRAM_DI = buf_data;
        end else if (wr_dp) begin
            SRAM_EN = 1'b1;
            SRAM_WE = dp_mask_q;
            SRAM_A  = dp_addr_q;
            SRAM_DI = ahb.HWDATA;
        end
    end

    ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .rd_req_i   (rd_req),
        .wr_dp_i    (wr_dp),
        .wr_addr_i  (dp_addr_q),
        .wr_mask_i  (dp_mask_q),
        .wr_data_i  (ahb.HWDATA),
        .rd_addr_i  (dp_addr_q),
        .sram_do_i  (SRAM_DO),
        .drain_o    (buf_drain),
        .addr_o     (buf_addr),
        .mask_o     (buf_mask),
        .data_o     (buf_data),
        .fwd_data_o (fwd_data)
    );

    assign ahb.HRDATA    = (dp_valid_q && !dp_write_q) ? fwd_data : '0;
    assign ahb.HREADYOUT = (state_q != ST_ERR1);
    assign ahb.HRESP     = (state_q == ST_OKAY) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Bench for ahbl_sram_ctrl: directed scenarios plus random traffic checked
// against a transfer-level memory image and an SRAM macro model.
module tb_ahbl_sram_ctrl;
    import ahbl_pkg::*;

    localparam int unsigned AW = 12;
    localparam int K_IDLE = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            SRAM_EN;
    logic [3:0]      SRAM_WE;
    logic [AW-1:0]   SRAM_A;
    logic [31:0]     SRAM_DI;
    logic [31:0]     SRAM_DO;
    logic            mem_clr;
    logic [31:0]     mem  [0:(1<<AW)-1];
    logic [31:0]     gold [0:(1<<AW)-1];
    int              n_checks = 0;
    int              n_err    = 0;
    xfer_t           pend;

    ahbl_sram_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahbl_sram_ctrl #(.AW(AW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (bus),
        .SRAM_EN (SRAM_EN),
        .SRAM_WE (SRAM_WE),
        .SRAM_A  (SRAM_A),
        .SRAM_DI (SRAM_DI),
        .SRAM_DO (SRAM_DO)
    );

    always #5 HCLK = ~HCLK;

    // SRAM macro: registered read, output zero when not reading.
    always @(posedge HCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (SRAM_EN) begin
            for (int b = 0; b < 4; b++)
                if (SRAM_WE[b]) mem[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
        end
        SRAM_DO <= (SRAM_EN && SRAM_WE == 4'h0) ? mem[SRAM_A] : '0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input xfer_t x);
        logic [31:0] r = old;
        int lo = int'(x.addr[1:0]);
        int n  = 1 << int'(x.size);
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) r[8*b +: 8] = x.data[8*b +: 8];
        return r;
    endfunction

    function automatic xfer_t mk(input int k, input logic [31:0] a, input logic [2:0] s,
                                 input logic w, input logic [31:0] d);
        xfer_t x;
        x.kind = k; x.addr = a; x.size = s; x.wr = w; x.data = d;
        return x;
    endfunction

    function automatic xfer_t idle_x();
        return mk(K_IDLE, '0, '0, 1'b0, '0);
    endfunction

    task automatic drive_bus(input xfer_t x);
        if (x.kind == K_IDLE) begin
            case ($urandom_range(0, 2))
                0:       begin bus.HSEL = 1'b0; bus.HTRANS = 2'd2; end
                1:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'd0; end
                default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'd1; end
            endcase
            bus.HADDR  = $urandom;
            bus.HWRITE = 1'($urandom);
            bus.HSIZE  = 3'($urandom);
        end else begin
            bus.HSEL   = 1'b1;
            bus.HTRANS = 2'($urandom_range(2, 3));
            bus.HADDR  = x.addr;
            bus.HWRITE = x.wr;
            bus.HSIZE  = x.size;
        end
        bus.HWDATA = (pend.kind == K_OK && pend.wr) ? pend.data : $urandom;
    endtask

    task automatic check_dphase();
        if (pend.kind == K_OK) begin
            check("ok_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check("ok_hresp", 32'(bus.HRESP), 32'd0);
            if (pend.wr) gold[widx(pend.addr)] = merge(gold[widx(pend.addr)], pend);
            else check("hrdata", bus.HRDATA, gold[widx(pend.addr)]);
        end else begin
            check("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check("idle_hresp", 32'(bus.HRESP), 32'd0);
        end
    endtask

    // Drive the next address phase and check the transfer now in its data phase.
    task automatic issue(input xfer_t nx);
        if (pend.kind == K_ERR) begin
            drive_bus(idle_x()); #1;
            check("err1_hreadyout", 32'(bus.HREADYOUT), 32'd0);
            check("err1_hresp", 32'(bus.HRESP), 32'd1);
            check("err1_sram_en", 32'(SRAM_EN), 32'd0);
            @(negedge HCLK);
            drive_bus(idle_x()); #1;
            check("err2_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check("err2_hresp", 32'(bus.HRESP), 32'd1);
            check("err2_sram_en", 32'(SRAM_EN), 32'd0);
            @(negedge HCLK);
            pend = idle_x();
        end
        drive_bus(nx); #1;
        check_dphase();
        pend = nx;
    endtask

    task automatic cycle(input xfer_t nx);
        issue(nx);
        @(negedge HCLK);
    endtask

    function automatic xfer_t rand_ok(input logic w);
        logic [2:0]  s   = 3'($urandom_range(0, 2));
        logic [1:0]  off = (s == HSIZE_BYTE) ? 2'($urandom) : (s == HSIZE_HALF) ? {1'($urandom), 1'b0} : 2'b00;
        logic [31:0] a   = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2) | 32'(off);
        return mk(K_OK, a, s, w, $urandom);
    endfunction

    function automatic xfer_t rand_err();
        logic [31:0] a = $urandom;
        case ($urandom_range(0, 2))
            0:       return mk(K_ERR, a, 3'($urandom_range(3, 7)), 1'($urandom), '0);
            1:       return mk(K_ERR, {a[31:1], 1'b1}, HSIZE_HALF, 1'($urandom), '0);
            default: return mk(K_ERR, {a[31:2], 2'($urandom_range(1, 3))}, HSIZE_WORD, 1'($urandom), '0);
        endcase
    endfunction

    initial begin
        logic [31:0] saved;
        HRESETn = 1'b0;
        mem_clr = 1'b1;
        pend    = idle_x();
        for (int i = 0; i < (1 << AW); i++) gold[i] = '0;
        drive_bus(idle_x());
        repeat (2) @(negedge HCLK);
        #1;
        check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("rst_hresp", 32'(bus.HRESP), 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        check("rst_sram_en", 32'(SRAM_EN), 32'd0);
        check("rst_sram_we", 32'(SRAM_WE), 32'd0);
        check("rst_sram_a", 32'(SRAM_A), 32'd0);
        check("rst_sram_di", SRAM_DI, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        mem_clr = 1'b0;

        // Word write then read back.
        cycle(mk(K_OK, 32'h10, HSIZE_WORD, 1'b1, 32'hDEAD_BEEF));
        issue(idle_x());
        check("t1_sram_we", 32'(SRAM_WE), 32'h0000_000F);
        check("t1_sram_a", 32'(SRAM_A), 32'd4);
        check("t1_sram_di", SRAM_DI, 32'hDEAD_BEEF);
        @(negedge HCLK);
        cycle(mk(K_OK, 32'h10, HSIZE_WORD, 1'b0, '0));
        cycle(idle_x());

        // Byte write into a known word.
        cycle(mk(K_OK, 32'h10, HSIZE_WORD, 1'b1, 32'h1122_3344));
        cycle(idle_x());
        cycle(mk(K_OK, 32'h13, HSIZE_BYTE, 1'b1, 32'hAA00_0000));
        issue(idle_x());
        check("t2_sram_we", 32'(SRAM_WE), 32'h0000_0008);
        @(negedge HCLK);
        cycle(mk(K_OK, 32'h10, HSIZE_WORD, 1'b0, '0));
        issue(idle_x());
        check("t2_hrdata", bus.HRDATA, 32'hAA22_3344);
        @(negedge HCLK);

        // Write immediately followed by a read of the same word.
        cycle(mk(K_OK, 32'h20, HSIZE_WORD, 1'b1, 32'hCAFE_F00D));
        issue(mk(K_OK, 32'h20, HSIZE_WORD, 1'b0, '0));
        check("t3_rd_we", 32'(SRAM_WE), 32'd0);
        @(negedge HCLK);
        issue(idle_x());
        check("t3_drain_en", 32'(SRAM_EN), 32'd1);
        check("t3_drain_we", 32'(SRAM_WE), 32'h0000_000F);
        check("t3_drain_a", 32'(SRAM_A), 32'd8);
        @(negedge HCLK);

        // Write held by eight back-to-back reads, drained on IDLE.
        cycle(mk(K_OK, 32'h40, HSIZE_WORD, 1'b1, 32'h5A5A_1234));
        for (int i = 0; i < 8; i++) cycle(mk(K_OK, 32'h100 + 32'(i * 4), HSIZE_WORD, 1'b0, '0));
        issue(idle_x());
        check("t4_drain_we", 32'(SRAM_WE), 32'h0000_000F);
        check("t4_drain_a", 32'(SRAM_A), 32'd16);
        @(negedge HCLK);
        cycle(mk(K_OK, 32'h40, HSIZE_WORD, 1'b0, '0));
        cycle(idle_x());

        // Error responses: misaligned half-word, then HSIZE=3.
        cycle(mk(K_ERR, 32'h01, HSIZE_HALF, 1'b0, '0));
        cycle(mk(K_ERR, 32'h00, 3'd3, 1'b1, '0));
        cycle(idle_x());

        // Reset while a buffered write is pending discards it.
        cycle(mk(K_OK, 32'h30, HSIZE_WORD, 1'b1, 32'h1234_5678));
        cycle(idle_x());
        cycle(mk(K_OK, 32'h30, HSIZE_WORD, 1'b1, 32'h8765_4321));
        saved = gold[12];
        issue(mk(K_OK, 32'h34, HSIZE_WORD, 1'b0, '0));
        @(negedge HCLK);
        HRESETn = 1'b0;
        drive_bus(idle_x());
        #1;
        check("arst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("arst_hresp", 32'(bus.HRESP), 32'd0);
        check("arst_hrdata", bus.HRDATA, 32'd0);
        check("arst_sram_en", 32'(SRAM_EN), 32'd0);
        check("arst_sram_we", 32'(SRAM_WE), 32'd0);
        check("arst_sram_a", 32'(SRAM_A), 32'd0);
        check("arst_sram_di", SRAM_DI, 32'd0);
        gold[12] = saved;
        pend = idle_x();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        cycle(mk(K_OK, 32'h30, HSIZE_WORD, 1'b0, '0));
        issue(idle_x());
        check("t6_prewrite", bus.HRDATA, 32'h1234_5678);
        @(negedge HCLK);

        // Random mixed traffic over a small aliased window.
        for (int n = 0; n < 400; n++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r < 3)      cycle(idle_x());
            else if (r < 6) cycle(rand_ok(1'b0));
            else if (r < 9) cycle(rand_ok(1'b1));
            else            cycle(rand_err());
        end
        repeat (3) cycle(idle_x());

        for (int i = 0; i < 80; i++) check($sformatf("resident_%0d", i), mem[i], gold[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_ctrl.md
Name: ahbl_sram_ctrl

Overview:
- AHB-Lite subordinate that drives the single-port synchronous 32-bit SRAM macro interface (EN, byte WE, A, Di in; Do out).
- SRAM timing: registered read, Do valid the cycle after EN; Do forced to 0 when EN is low.
- Zero-wait-state reads and writes. A one-entry posted-write buffer resolves read/write port contention, with byte-accurate forwarding.
- Sits between the SoC AHB-Lite interconnect and each RAM_4Kx32 instance.

Parameters:
- AW, 12, word-address width driven to the SRAM (depth = 2^AW words).

Ports:
- HCLK  input  1  system clock; the SRAM is clocked by the same net.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  subordinate select.
- HADDR  input  32  byte address; only [AW+1:0] is used.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = half, 2 = word.
- HREADY  input  1  bus ready; qualifies the address phase.
- HWDATA  input  32  write data, valid in the data phase.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  subordinate ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- SRAM_EN  output  1  SRAM enable.
- SRAM_WE  output  4  SRAM byte write enables.
- SRAM_A  output  AW  SRAM word address.
- SRAM_DI  output  32  SRAM write data.
- SRAM_DO  input  32  SRAM read data.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAM_EN=0, SRAM_WE=0, SRAM_A=0, SRAM_DI=0. Write buffer is invalid.
- Reset mid-operation discards any buffered write.
- Accept: an address phase is accepted when HSEL & HREADY & HTRANS[1].
  - On accept, register dir, word address HADDR[AW+1:2], and byte mask.
  - Byte mask: byte 4'b0001<<HADDR[1:0]; half 4'b0011<<{HADDR[1],1'b0}; word 4'b1111.
- IDLE/BUSY or HSEL=0: OKAY response, zero wait, no SRAM access.
- Error: HSIZE>2, or misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=0), gives the two-cycle ERROR response.
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - No SRAM access and no buffer change.
- SRAM port arbitration (combinational, fixed priority, one access per cycle):
  1. Accepted read address phase: EN=1, WE=0, A=HADDR[AW+1:2].
  2. Else, buffer valid: drain it (EN=1, WE=buf_mask, A=buf_addr, Di=buf_data); buffer clears at the clock edge.
  3. Else, write data phase: direct write (EN=1, WE=mask, A=reg addr, Di=HWDATA).
  4. Else EN=0.
- Write data phase routing: if the port is taken by a read or by a drain, load HWDATA, mask and address into the buffer.
- Buffer occupancy: the buffer can never be valid and loaded in the same cycle, because every write data phase follows a write address phase in which the port is free.
  - Implement an assertion that flags a load into a valid buffer.
- Read data phase: HRDATA = SRAM_DO with each byte lane i replaced by buf_data lane i when buffer valid, buf_addr equals the read address, and buf_mask[i]=1.
  - This compare uses the buffer register value in the data-phase cycle, which is still valid during a drain cycle.
- Latency: every OKAY transfer completes with HREADYOUT=1 (zero wait).
- Write data becomes SRAM-resident within 1 cycle, or at the first cycle without a read address phase.
- Back-to-back reads may hold the buffer indefinitely; forwarding keeps reads coherent meanwhile.
- Address bits above AW+1 are ignored (aliasing/wrap-around).

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS encodings.
  - HSIZE encodings.
  - HRESP encodings.
  - Byte-mask function taking size and addr[1:0].
- One natural sub-module: ahbl_sram_wbuf, the posted-write buffer holding valid, addr, mask and data, plus forwarding mux and load/drain control.
- Arbitration and the AHB phase registers stay in the top level.

Test Plan:
- Word write 0xDEADBEEF @0x10 (idle next), then read @0x10 -> SRAM_WE=4'hF, SRAM_A=4 in the data phase; HRDATA=0xDEADBEEF, zero wait.
- Byte write 0xAA to 0x13 over 0x11223344, then word read @0x10 -> SRAM_WE=4'b1000, HRDATA=0xAA223344.
- Write @0x20 immediately followed by read @0x20 (data 0xCAFEF00D, prior 0) -> write is buffered; HRDATA=0xCAFEF00D via forwarding; SRAM updated in the next non-read cycle.
- Write then 8 back-to-back reads of other addresses, then IDLE -> buffer drains at the IDLE cycle; a read of the written address returns the new data; no wait states throughout.
- Half-word access at 0x01, and HSIZE=3 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1); SRAM_EN stays 0.
- Assert HRESETn=0 while the buffer is valid -> all outputs go to reset values asynchronously; the subsequent read returns the pre-write value.
